lsu_mmio: RTL

Parametrised load/store unit for the next-generation core. It replaces the single-cycle, combinational dmem/UART path with a handshaked unit that stalls the core until the access completes. It owns a synchronous data RAM and decodes MMIO addresses for UART data and status. It supports byte, half and word access with sign or zero extension, blocking UART handshakes, and misalignment detection.

---
 rtl/lsu_mmio.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mmio.sv
// Handshaked load/store unit: synchronous data RAM plus UART data/status MMIO.
// Optional RX wait timeout is enabled by defining LSU_RX_TIMEOUT_EN.
module lsu_mmio #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     DMEM_WORDS     = 1024,
  parameter logic [XLEN-1:0] UART_DATA_ADDR = 32'hFFFF_0000,
  parameter logic [XLEN-1:0] UART_STAT_ADDR = 32'hFFFF_0004,
  parameter int unsigned     TIMEOUT_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            err_misaligned,
  output logic            err_timeout,
  input  logic [7:0]      uart_rx_data,
  input  logic            empty,
  output logic            uart_rd_en,
  output logic [7:0]      uart_tx_data,
  input  logic            full,
  output logic            uart_wr_en
);

  localparam int unsigned     AW         = $clog2(DMEM_WORDS);
  localparam logic [XLEN-1:0] DMEM_BYTES = XLEN'(4 * DMEM_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEM_RD  = 3'd1;
  localparam logic [2:0] S_RX_WAIT = 3'd2;
  localparam logic [2:0] S_TX_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      off_q, off_d;
  logic [7:0]      tx_byte_q, tx_byte_d;

  logic            req_ready_d, rsp_valid_d, err_mis_d, rd_en_d, wr_en_d;
  logic [XLEN-1:0] rsp_rdata_d;
  logic [7:0]      tx_data_d;

  logic            ram_we, ram_re;
  logic [3:0]      ram_be;
  logic [XLEN-1:0] ram_wdata, ram_q;
  logic [AW-1:0]   ram_idx;
  logic [XLEN-1:0] mem [DMEM_WORDS];

  logic is_byte, is_half, misaligned, hit_data, hit_stat, hit_dmem;

`ifdef LSU_RX_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          err_to_d;
`endif

  // Request decode, evaluated on the accept cycle
  assign is_byte    = (req_size == 2'b00);
  assign is_half    = (req_size == 2'b01);
  assign misaligned = (is_half && req_addr[0]) ||
                      (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
  assign hit_data   = (req_addr == UART_DATA_ADDR);
  assign hit_stat   = (req_addr == UART_STAT_ADDR);
  assign hit_dmem   = (req_addr < DMEM_BYTES);
  assign ram_idx    = req_addr[AW+1:2];

  // Big-endian lane select and extension of a RAM word
  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] w,
                                               input logic [1:0] off,
                                               input logic [1:0] sz,
                                               input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   load_fmt = uns ? XLEN'(b) : {{(XLEN-8){b[7]}}, b};
      2'b01:   load_fmt = uns ? XLEN'(h) : {{(XLEN-16){h[15]}}, h};
      default: load_fmt = w;
    endcase
  endfunction

  // UART bytes only sign-extend for signed byte loads
  function automatic logic [XLEN-1:0] rx_ext(input logic [7:0] d,
                                             input logic [1:0] sz,
                                             input logic uns);
    rx_ext = ((sz == 2'b00) && !uns) ? {{(XLEN-8){d[7]}}, d} : XLEN'(d);
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    tx_byte_d   = tx_byte_q;
    rsp_rdata_d = '0;
    err_mis_d   = 1'b0;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    tx_data_d   = uart_tx_data;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_be      = 4'b0000;
    ram_wdata   = '0;
`ifdef LSU_RX_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_to_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d    = req_size;
          uns_d     = req_unsigned;
          off_d     = req_addr[1:0];
          tx_byte_d = req_wdata[7:0];
`ifdef LSU_RX_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          if (misaligned) begin
            err_mis_d = 1'b1;
            state_d   = S_RESP;
          end else if (hit_data) begin
            state_d = req_we ? S_TX_WAIT : S_RX_WAIT;
          end else if (hit_stat) begin
            rsp_rdata_d = req_we ? '0 : XLEN'({~full, ~empty});
            state_d     = S_RESP;
          end else if (hit_dmem) begin
            if (req_we) begin
              ram_we = 1'b1;
              if (is_byte) begin
                ram_be    = 4'b1000 >> req_addr[1:0];
                ram_wdata = XLEN'({4{req_wdata[7:0]}});
              end else if (is_half) begin
                ram_be    = req_addr[1] ? 4'b0011 : 4'b1100;
                ram_wdata = XLEN'({2{req_wdata[15:0]}});
              end else begin
                ram_be    = 4'b1111;
                ram_wdata = req_wdata;
              end
              state_d = S_RESP;
            end else begin
              ram_re  = 1'b1;
              state_d = S_MEM_RD;
            end
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_MEM_RD: begin
        rsp_rdata_d = load_fmt(ram_q, off_q, size_q, uns_q);
        state_d     = S_RESP;
      end
      S_RX_WAIT: begin
        if (!empty) begin
          rd_en_d     = 1'b1;
          rsp_rdata_d = rx_ext(uart_rx_data, size_q, uns_q);
          state_d     = S_RESP;
        end
`ifdef LSU_RX_TIMEOUT_EN
        else if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d = '1;
          err_to_d    = 1'b1;
          state_d     = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
`endif
      end
      S_TX_WAIT: begin
        if (!full) begin
          wr_en_d   = 1'b1;
          tx_data_d = tx_byte_q;
          state_d   = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      off_q          <= 2'b00;
      tx_byte_q      <= 8'h00;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      err_misaligned <= 1'b0;
      uart_rd_en     <= 1'b0;
      uart_wr_en     <= 1'b0;
      uart_tx_data   <= 8'h00;
    end else begin
      state_q        <= state_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      off_q          <= off_d;
      tx_byte_q      <= tx_byte_d;
      req_ready      <= req_ready_d;
      rsp_valid      <= rsp_valid_d;
      rsp_rdata      <= rsp_rdata_d;
      err_misaligned <= err_mis_d;
      uart_rd_en     <= rd_en_d;
      uart_wr_en     <= wr_en_d;
      uart_tx_data   <= tx_data_d;
    end
  end

`ifdef LSU_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q    <= '0;
      err_timeout <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      err_timeout <= err_to_d;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  // Data RAM; writes are suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (ram_we && rstn) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_re) ram_q <= mem[ram_idx];
  end

endmodule
